// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a requester and bin_to_bcd_seq.
//   start    : conversion request (requester -> converter)
//   bin      : unsigned value to convert, sampled on the accept edge
//   busy     : conversion in progress
//   done     : one-cycle pulse, bcd/overflow freshly updated
//   overflow : last accepted value did not fit in DIGITS decimal digits
//   bcd      : packed BCD digits, digit k at [4k+3:4k]
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd;

    modport master (output start, bin, input busy, done, overflow, bcd);
    modport slave  (input start, bin, output busy, done, overflow, bcd);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// feeding per-digit seven-segment decoders. Nibble 4'hF means "blank".
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   io  : slave side of bin_to_bcd_seq_if (start/bin in; busy/done/
//         overflow/bcd out)
module bin_to_bcd_seq #(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 0
) (
    input  logic               clk,
    input  logic               rst,
    bin_to_bcd_seq_if.slave    io
);
    localparam int DW = 4 * DIGITS;
    localparam int SW = DW + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // Largest value representable in DIGITS decimal digits.
    localparam logic [31:0] MAX_VAL = 32'(pow10(DIGITS) - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              ovf_q, ovf_d;
    logic [DW-1:0]     bcd_q, bcd_d;
    logic              done_q, done_d;

    // One double-dabble iteration: correct every digit field that would
    // exceed 9 after doubling, then shift the whole register left.
    function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] s);
        logic [SW-1:0] t;
        t = s;
        for (int k = 0; k < DIGITS; k++) begin
            if (t[BIN_W+4*k +: 4] >= 4'd5)
                t[BIN_W+4*k +: 4] = t[BIN_W+4*k +: 4] + 4'd3;
        end
        return {t[SW-2:0], 1'b0};
    endfunction

    // Final presentation: all-blank on overflow, optional leading-zero
    // blanking otherwise. Digit 0 is never blanked so zero shows as "0".
    function automatic logic [DW-1:0] format_digits(input logic [DW-1:0] d,
                                                    input logic ovf);
        logic [DW-1:0] r;
        logic          lead;
        r    = d;
        lead = 1'b1;
        if (ovf) begin
            r = '1;
        end else if (BLANK_LZ != 0) begin
            for (int k = DIGITS - 1; k >= 1; k--) begin
                if (lead && (r[4*k +: 4] == 4'd0))
                    r[4*k +: 4] = 4'hF;
                else
                    lead = 1'b0;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            bcd_q      <= bcd_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        bcd_d      = bcd_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d    = SHIFT;
                    scratch_d  = {{DW{1'b0}}, io.bin};
                    cnt_d      = '0;
                    // Overflow is decided up front; the digit field loses
                    // its top bits for such values and is not trusted.
                    ovf_pend_d = (32'(io.bin) > MAX_VAL);
                end
            end
            SHIFT: begin
                scratch_d = dabble_step(scratch_q);
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_pend_q;
                    bcd_d   = format_digits(scratch_d[SW-1:BIN_W], ovf_pend_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io.busy     = (state_q == SHIFT);
    assign io.done     = done_q;
    assign io.overflow = ovf_q;
    assign io.bcd      = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscomp = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) if0 ();
    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) if1 ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst(rst), .io(if0.slave));
    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .BLANK_LZ(1)) dut1 (
        .clk(clk), .rst(rst), .io(if1.slave));

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          acc;
        int          val;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   bc0 = 0, bc1 = 0;

    // Reference: decimal digits by division, blanking by magnitude.
    function automatic logic [15:0] ref_bcd(input int v, input bit blank);
        logic [15:0] r;
        int p;
        r = '0;
        p = 1;
        if (v > 9999) return 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            if (blank && k > 0 && v < p) r[4*k +: 4] = 4'hF;
            else r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscomp++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic mon_done(input int which, input logic [15:0] bcd,
                            input logic ovf, input int bc);
        exp_t e;
        vectors++;
        if (which == 0 ? q0.size() == 0 : q1.size() == 0) begin
            miscomp++;
            $display("FAIL dut%0d unexpected_done: bcd=%h, no conversion expected", which, bcd);
        end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            if (bcd !== e.bcd || ovf !== e.ovf || (cyc - e.acc) != 14 || bc != 14) begin
                miscomp++;
                $display("FAIL dut%0d conv(%0d): bcd=%h ovf=%b lat=%0d busy=%0d, expected bcd=%h ovf=%b lat=14 busy=14",
                         which, e.val, bcd, ovf, cyc - e.acc, bc, e.bcd, e.ovf);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst) begin
            bc0 = 0;
            bc1 = 0;
        end else begin
            if (if0.busy) bc0++;
            if (if1.busy) bc1++;
            if (if0.done) begin mon_done(0, if0.bcd, if0.overflow, bc0); bc0 = 0; end
            if (if1.done) begin mon_done(1, if1.bcd, if1.overflow, bc1); bc1 = 0; end
            if ((if0.busy && if0.done) || (if1.busy && if1.done)) begin
                vectors++;
                miscomp++;
                $display("FAIL busy_done_overlap: busy and done both high at cycle %0d", cyc);
            end
        end
    end

    task automatic wait_idle(input int which);
        int n;
        n = 0;
        @(negedge clk);
        while ((which == 0 ? if0.busy : if1.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscomp++;
            $display("FAIL dut%0d idle_timeout: busy=1, expected 0", which);
        end
    endtask

    task automatic wait_done0(output int at);
        int n;
        n = 0;
        at = -1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (if0.done) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            vectors++;
            miscomp++;
            $display("FAIL done_timeout: done=0, expected 1");
        end
    endtask

    task automatic conv(input int which, input int v);
        exp_t e;
        wait_idle(which);
        if (which == 0) begin if0.start = 1'b1; if0.bin = 14'(v); end
        else begin if1.start = 1'b1; if1.bin = 14'(v); end
        @(negedge clk);
        e.bcd = ref_bcd(v, which == 1);
        e.ovf = (v > 9999);
        e.acc = cyc;
        e.val = v;
        if (which == 0) begin q0.push_back(e); if0.start = 1'b0; if0.bin = 14'($urandom); end
        else begin q1.push_back(e); if1.start = 1'b0; if1.bin = 14'($urandom); end
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscomp++;
            $display("FAIL drain_timeout: %0d/%0d results outstanding, expected 0", q0.size(), q1.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2;
        exp_t e;
        if0.start = 1'b0; if0.bin = '0;
        if1.start = 1'b0; if1.bin = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(if0.busy), 0);
        check("rst_done", int'(if0.done), 0);
        check("rst_ovf", int'(if0.overflow), 0);
        check("rst_bcd", int'(if0.bcd), 0);
        check("rst_bcd_blank", int'(if1.bcd), 0);
        rst = 1'b0;

        // Directed values, default (no blanking) instance.
        conv(0, 0);
        conv(0, 9999);
        conv(0, 10000);
        conv(0, 16383);
        conv(0, 1234);
        // Blanking instance.
        conv(1, 42);
        conv(1, 0);
        conv(1, 1000);
        conv(1, 7);
        conv(1, 10000);
        drain();

        // Random values on both instances.
        for (int i = 0; i < 20; i++) begin
            conv(0, (i % 3 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 16383)));
            conv(1, (i % 3 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 16383)));
        end
        drain();

        // start pulses while busy must be ignored.
        conv(0, 5678);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3 || i == 9) begin if0.start = 1'b1; if0.bin = 14'd1111; end
            else if0.start = 1'b0;
        end
        if0.start = 1'b0;
        wait_done0(d1);
        repeat (20) @(negedge clk);
        check("ignored_start_queue", q0.size(), 0);

        // start held high across the done cycle: back-to-back accept.
        wait_idle(0);
        if0.start = 1'b1;
        if0.bin   = 14'd5678;
        @(negedge clk);
        e.bcd = 16'h5678; e.ovf = 1'b0; e.acc = cyc; e.val = 5678;
        q0.push_back(e);
        if0.bin = 14'd1111;
        wait_done0(d1);
        @(negedge clk);
        e.bcd = 16'h1111; e.ovf = 1'b0; e.acc = cyc; e.val = 1111;
        q0.push_back(e);
        if0.start = 1'b0;
        wait_done0(d2);
        check("b2b_gap", d2 - d1, 15);
        drain();

        // Reset in mid-conversion aborts it.
        wait_idle(0);
        if0.start = 1'b1;
        if0.bin   = 14'd4321;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", int'(if0.busy), 0);
        check("abort_done", int'(if0.done), 0);
        check("abort_bcd", int'(if0.bcd), 0);
        check("abort_ovf", int'(if0.overflow), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done_bcd", int'(if0.bcd), 0);
        conv(0, 4321);
        drain();
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
        $finish;
    end
endmodule
